// File: rtl/core_interface_sequencer_if.sv
// Operand/result streams and the core command bus of the interface sequencer.
// Signal suffixes are from the sequencer's point of view (master modport).
interface core_interface_sequencer_if;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [31:0] op_data_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        res_last_o;
    logic [7:0]  instruction_o;
    logic [23:0] address_o;
    logic [31:0] value_o;
    logic [31:0] result_i;

    modport master (
        input  op_valid_i,
        output op_ready_o,
        input  op_data_i,
        output res_valid_o,
        input  res_ready_i,
        output res_data_o,
        output res_last_o,
        output instruction_o,
        output address_o,
        output value_o,
        input  result_i
    );

    modport slave (
        output op_valid_i,
        input  op_ready_o,
        output op_data_i,
        input  res_valid_o,
        output res_ready_i,
        input  res_data_o,
        input  res_last_o,
        input  instruction_o,
        input  address_o,
        input  value_o,
        output result_i
    );
endinterface

// File: rtl/core_interface_sequencer.sv
// Streams operands into a memory-mapped core, waits for it to compute, then
// reads the results back one at a time and streams them out.
module core_interface_sequencer #(
    parameter int          TOTAL_INPUTS    = 2,
    parameter int          TOTAL_OUTPUTS   = 1,
    parameter logic [23:0] START_ADDRESS   = 24'h000000,
    parameter int          COMPUTE_LATENCY = 2,
    parameter int          READ_LATENCY    = 1,
    parameter logic [7:0]  OP_NOP          = 8'h00,
    parameter logic [7:0]  OP_WRITE        = 8'h01,
    parameter logic [7:0]  OP_READ         = 8'h02
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    output logic                       busy_o,
    core_interface_sequencer_if.master bus
);

    localparam int OP_CNT_W  = $clog2(TOTAL_INPUTS  > 2 ? TOTAL_INPUTS  : 2);
    localparam int RES_CNT_W = $clog2(TOTAL_OUTPUTS > 2 ? TOTAL_OUTPUTS : 2);
    localparam int WAIT_W    = $clog2(COMPUTE_LATENCY + 2);
    localparam int RLAT_W    = $clog2(READ_LATENCY + 2);

    localparam logic [OP_CNT_W-1:0]  LAST_OP   = OP_CNT_W'(TOTAL_INPUTS - 1);
    localparam logic [RES_CNT_W-1:0] LAST_RES  = RES_CNT_W'(TOTAL_OUTPUTS - 1);
    localparam logic [WAIT_W-1:0]    WAIT_END  = WAIT_W'(COMPUTE_LATENCY);
    localparam logic [RLAT_W-1:0]    RLAT_END  = RLAT_W'(READ_LATENCY);
    localparam logic [23:0]          READ_BASE = START_ADDRESS + 24'(TOTAL_INPUTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_READ,
        ST_RWAIT,
        ST_OUTPUT
    } state_t;

    state_t                 state_q,     state_d;
    logic [OP_CNT_W-1:0]    op_cnt_q,    op_cnt_d;
    logic [RES_CNT_W-1:0]   res_cnt_q,   res_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q,  wait_cnt_d;
    logic [RLAT_W-1:0]      rlat_cnt_q,  rlat_cnt_d;
    logic [7:0]             instr_q,     instr_d;
    logic [23:0]            addr_q,      addr_d;
    logic [31:0]            value_q,     value_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_last_q,  res_last_d;
    logic [31:0]            res_data_q,  res_data_d;
    logic                   op_ready_q,  op_ready_d;
    logic                   busy_q,      busy_d;

    logic op_fire;
    logic res_fire;

    assign op_fire  = bus.op_valid_i  && op_ready_q;
    assign res_fire = bus.res_ready_i && res_valid_q;

    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        res_cnt_d   = res_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rlat_cnt_d  = rlat_cnt_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_data_d  = res_data_q;
        // The command bus idles at NOP/0/0 unless a command is issued this cycle.
        instr_d     = OP_NOP;
        addr_d      = 24'd0;
        value_d     = 32'd0;

        if (clear_i) begin
            state_d     = ST_IDLE;
            op_cnt_d    = '0;
            res_cnt_d   = '0;
            wait_cnt_d  = '0;
            rlat_cnt_d  = '0;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_data_d  = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WRITE: begin
                    if (op_fire) begin
                        instr_d = OP_WRITE;
                        addr_d  = START_ADDRESS + 24'(op_cnt_q);
                        value_d = bus.op_data_i;
                        if (op_cnt_q == LAST_OP) begin
                            state_d    = ST_WAIT;
                            op_cnt_d   = '0;
                            wait_cnt_d = '0;
                        end else begin
                            state_d  = ST_WRITE;
                            op_cnt_d = op_cnt_q + 1'b1;
                        end
                    end
                end
                // WAIT covers the last write cycle plus COMPUTE_LATENCY idle cycles.
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_END) begin
                        state_d    = ST_READ;
                        wait_cnt_d = '0;
                        instr_d    = OP_READ;
                        addr_d     = READ_BASE + 24'(res_cnt_q);
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_READ: begin
                    state_d    = ST_RWAIT;
                    rlat_cnt_d = RLAT_W'(1);
                end
                ST_RWAIT: begin
                    if (rlat_cnt_q == RLAT_END) begin
                        state_d     = ST_OUTPUT;
                        rlat_cnt_d  = '0;
                        res_data_d  = bus.result_i;
                        res_valid_d = 1'b1;
                        res_last_d  = (res_cnt_q == LAST_RES);
                    end else begin
                        rlat_cnt_d = rlat_cnt_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (res_fire) begin
                        res_valid_d = 1'b0;
                        res_last_d  = 1'b0;
                        if (res_cnt_q == LAST_RES) begin
                            state_d   = ST_IDLE;
                            res_cnt_d = '0;
                        end else begin
                            state_d   = ST_READ;
                            res_cnt_d = res_cnt_q + 1'b1;
                            instr_d   = OP_READ;
                            addr_d    = READ_BASE + 24'(res_cnt_q) + 24'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered from the next state so they line up with state_q.
        op_ready_d = (state_d == ST_IDLE) || (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            op_cnt_q    <= '0;
            res_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            rlat_cnt_q  <= '0;
            instr_q     <= OP_NOP;
            addr_q      <= 24'd0;
            value_q     <= 32'd0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= 32'd0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_cnt_q    <= op_cnt_d;
            res_cnt_q   <= res_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rlat_cnt_q  <= rlat_cnt_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.op_ready_o    = op_ready_q;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_last_o    = res_last_q;
    assign bus.instruction_o = instr_q;
    assign bus.address_o     = addr_q;
    assign bus.value_o       = value_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_core_interface_sequencer.sv
// Directed bench for core_interface_sequencer: three configurations, each
// backed by a small adder-style core model.
module tb_core_interface_sequencer;

    localparam logic [7:0] NOP = 8'h00;
    localparam logic [7:0] WR  = 8'h01;
    localparam logic [7:0] RD  = 8'h02;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic        op_valid;
    logic        res_ready;
    logic [31:0] op_data;
    int          sel;

    int checks = 0;
    int errors = 0;

    core_interface_sequencer_if if_a ();
    core_interface_sequencer_if if_b ();
    core_interface_sequencer_if if_c ();

    logic busy_a, busy_b, busy_c;

    core_interface_sequencer u_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear && (sel == 0)),
        .busy_o  (busy_a),
        .bus     (if_a)
    );

    core_interface_sequencer #(
        .TOTAL_OUTPUTS (3),
        .START_ADDRESS (24'hFFFFFE)
    ) u_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear && (sel == 1)),
        .busy_o  (busy_b),
        .bus     (if_b)
    );

    core_interface_sequencer #(
        .COMPUTE_LATENCY (0),
        .READ_LATENCY    (3)
    ) u_c (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear && (sel == 2)),
        .busy_o  (busy_c),
        .bus     (if_c)
    );

    assign if_a.op_valid_i  = op_valid  && (sel == 0);
    assign if_b.op_valid_i  = op_valid  && (sel == 1);
    assign if_c.op_valid_i  = op_valid  && (sel == 2);
    assign if_a.res_ready_i = res_ready && (sel == 0);
    assign if_b.res_ready_i = res_ready && (sel == 1);
    assign if_c.res_ready_i = res_ready && (sel == 2);
    assign if_a.op_data_i   = op_data;
    assign if_b.op_data_i   = op_data;
    assign if_c.op_data_i   = op_data;

    // Core model: writes accumulate, a read of result j returns sum + 0x100*j,
    // valid only in the single cycle READ_LATENCY after the read command.
    logic [7:0]  m_instr [3];
    logic [23:0] m_addr  [3];
    logic [31:0] m_value [3];
    logic [31:0] m_res   [3];
    logic [31:0] acc     [3];
    logic [23:0] rd_addr [3];
    int          cnt     [3] = '{0, 0, 0};

    function automatic logic [23:0] m_base(input int i);
        return (i == 1) ? 24'hFFFFFE : 24'h000000;
    endfunction

    function automatic int m_rl(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    assign m_instr[0] = if_a.instruction_o;
    assign m_instr[1] = if_b.instruction_o;
    assign m_instr[2] = if_c.instruction_o;
    assign m_addr[0]  = if_a.address_o;
    assign m_addr[1]  = if_b.address_o;
    assign m_addr[2]  = if_c.address_o;
    assign m_value[0] = if_a.value_o;
    assign m_value[1] = if_b.value_o;
    assign m_value[2] = if_c.value_o;
    assign if_a.result_i = m_res[0];
    assign if_b.result_i = m_res[1];
    assign if_c.result_i = m_res[2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_instr[i] == WR)
                acc[i] <= (m_addr[i] == m_base(i)) ? m_value[i] : acc[i] + m_value[i];
            if (m_instr[i] == RD) begin
                cnt[i]     <= m_rl(i);
                rd_addr[i] <= m_addr[i];
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            m_res[i] = (cnt[i] == 1)
                     ? acc[i] + 32'h100 * 32'(rd_addr[i] - m_base(i) - 24'd2)
                     : 32'hDEADBEEF;
        end
    end

    // Observed outputs of the DUT currently under test.
    logic [7:0]  o_instr;
    logic [23:0] o_addr;
    logic [31:0] o_value;
    logic [31:0] o_data;
    logic        o_rdy, o_busy, o_vld, o_last;

    always_comb begin
        o_instr = if_a.instruction_o;
        o_addr  = if_a.address_o;
        o_value = if_a.value_o;
        o_data  = if_a.res_data_o;
        o_rdy   = if_a.op_ready_o;
        o_busy  = busy_a;
        o_vld   = if_a.res_valid_o;
        o_last  = if_a.res_last_o;
        if (sel == 1) begin
            o_instr = if_b.instruction_o;
            o_addr  = if_b.address_o;
            o_value = if_b.value_o;
            o_data  = if_b.res_data_o;
            o_rdy   = if_b.op_ready_o;
            o_busy  = busy_b;
            o_vld   = if_b.res_valid_o;
            o_last  = if_b.res_last_o;
        end else if (sel == 2) begin
            o_instr = if_c.instruction_o;
            o_addr  = if_c.address_o;
            o_value = if_c.value_o;
            o_data  = if_c.res_data_o;
            o_rdy   = if_c.op_ready_o;
            o_busy  = busy_c;
            o_vld   = if_c.res_valid_o;
            o_last  = if_c.res_last_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [7:0] i, input logic [23:0] a,
                           input logic [31:0] v);
        check({tag, ".instr"}, 32'(o_instr), 32'(i));
        check({tag, ".addr"},  32'(o_addr),  32'(a));
        check({tag, ".value"}, o_value, v);
    endtask

    task automatic chk_rd(input string tag, input logic [23:0] a);
        check({tag, ".instr"}, 32'(o_instr), 32'(RD));
        check({tag, ".addr"},  32'(o_addr),  32'(a));
    endtask

    // ctl packs {op_ready, busy, res_valid, res_last}
    task automatic chk_ctl(input string tag, input logic rdy, input logic bsy,
                           input logic vld, input logic lst);
        check({tag, ".ctl"}, {28'd0, o_rdy, o_busy, o_vld, o_last},
              {28'd0, rdy, bsy, vld, lst});
    endtask

    // Two-operand, one-result transaction on a DUT with base address 0.
    task automatic run_txn(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] exp, input int cl, input int rl);
        res_ready = 1'b1;
        op_valid  = 1'b1;
        op_data   = d0;
        tick();
        chk_bus({tag, "_w0"}, WR, 24'd0, d0);
        chk_ctl({tag, "_w0"}, 1'b1, 1'b1, 1'b0, 1'b0);
        op_data = d1;
        tick();
        chk_bus({tag, "_w1"}, WR, 24'd1, d1);
        chk_ctl({tag, "_w1"}, 1'b0, 1'b1, 1'b0, 1'b0);
        op_valid = 1'b0;
        op_data  = 32'd0;
        for (int i = 0; i < cl; i++) begin
            tick();
            chk_bus({tag, "_wait"}, NOP, 24'd0, 32'd0);
        end
        tick();
        chk_rd({tag, "_rd"}, 24'd2);
        chk_ctl({tag, "_rd"}, 1'b0, 1'b1, 1'b0, 1'b0);
        // Operands offered while the sequencer is not ready must be ignored.
        op_valid = 1'b1;
        op_data  = 32'h0000_0099;
        for (int i = 0; i < rl; i++) begin
            tick();
            chk_bus({tag, "_rwait"}, NOP, 24'd0, 32'd0);
            chk_ctl({tag, "_rwait"}, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_ctl({tag, "_out"}, 1'b0, 1'b1, 1'b1, 1'b1);
        check({tag, "_res"}, o_data, exp);
        tick();
        chk_ctl({tag, "_idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_bus({tag, "_idle"}, NOP, 24'd0, 32'd0);
        op_valid = 1'b0;
        op_data  = 32'd0;
        $display("txn %s: %h + %h done", tag, d0, d1);
    endtask

    initial begin
        sel       = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        op_valid  = 1'b0;
        op_data   = 32'd0;
        res_ready = 1'b0;

        tick();
        tick();
        chk_bus("reset", NOP, 24'd0, 32'd0);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_ctl("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Defaults: 5 + 7
        run_txn("a_basic", 32'd5, 32'd7, 32'd12, 2, 1);

        // Gapped operands with a 3-cycle bubble
        res_ready = 1'b1;
        op_valid  = 1'b1;
        op_data   = 32'h1000_0001;
        tick();
        chk_bus("a_gap_w0", WR, 24'd0, 32'h1000_0001);
        op_valid = 1'b0;
        op_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bus("a_gap_bubble", NOP, 24'd0, 32'd0);
            chk_ctl("a_gap_bubble", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        op_valid = 1'b1;
        op_data  = 32'h0000_00FF;
        tick();
        chk_bus("a_gap_w1", WR, 24'd1, 32'h0000_00FF);
        op_valid = 1'b0;
        repeat (3) tick();
        chk_rd("a_gap_rd", 24'd2);
        repeat (2) tick();
        chk_ctl("a_gap_out", 1'b0, 1'b1, 1'b1, 1'b1);
        check("a_gap_res", o_data, 32'h1000_0100);
        tick();
        chk_ctl("a_gap_idle", 1'b1, 1'b0, 1'b0, 1'b0);
        $display("txn a_gap done");

        // clear_i in RWAIT, then clear_i together with an offered operand
        op_valid = 1'b1;
        op_data  = 32'd1;
        tick();
        op_data = 32'd2;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        chk_rd("a_clr_rd", 24'd2);
        tick();
        clear = 1'b1;
        tick();
        chk_bus("a_clr", NOP, 24'd0, 32'd0);
        chk_ctl("a_clr", 1'b1, 1'b0, 1'b0, 1'b0);
        op_valid = 1'b1;
        op_data  = 32'h0000_0077;
        tick();
        chk_bus("a_clr_discard", NOP, 24'd0, 32'd0);
        chk_ctl("a_clr_discard", 1'b1, 1'b0, 1'b0, 1'b0);
        clear    = 1'b0;
        op_valid = 1'b0;
        $display("txn a_clear done");
        run_txn("a_after_clr", 32'd3, 32'd4, 32'd7, 2, 1);

        // Reset pulse while in WRITE
        op_valid = 1'b1;
        op_data  = 32'd3;
        tick();
        chk_bus("a_rst_w0", WR, 24'd0, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_bus("a_rst_abort", NOP, 24'd0, 32'd0);
        chk_ctl("a_rst_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        op_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_ctl("a_rst_ready", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_bus("a_rst_ready", NOP, 24'd0, 32'd0);
        $display("txn a_reset done");
        run_txn("a_after_rst", 32'd4, 32'd9, 32'd13, 2, 1);

        // Three results, wrapped addresses, consumer stalled 4 cycles each
        sel       = 1;
        res_ready = 1'b0;
        op_valid  = 1'b1;
        op_data   = 32'd10;
        tick();
        chk_bus("b_w0", WR, 24'hFFFFFE, 32'd10);
        op_data = 32'd20;
        tick();
        chk_bus("b_w1", WR, 24'hFFFFFF, 32'd20);
        op_valid = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 3; j++) begin
            chk_rd("b_rd", 24'(j));
            chk_ctl("b_rd", 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            chk_bus("b_rwait", NOP, 24'd0, 32'd0);
            chk_ctl("b_rwait", 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            for (int s = 0; s < 4; s++) begin
                chk_ctl("b_stall", 1'b0, 1'b1, 1'b1, (j == 2));
                check("b_stall_data", o_data, 32'd30 + 32'h100 * 32'(j));
                chk_bus("b_stall", NOP, 24'd0, 32'd0);
                tick();
            end
            res_ready = 1'b1;
            chk_ctl("b_hs", 1'b0, 1'b1, 1'b1, (j == 2));
            check("b_hs_data", o_data, 32'd30 + 32'h100 * 32'(j));
            tick();
            res_ready = 1'b0;
            $display("txn b_result %0d done", j);
        end
        chk_ctl("b_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // COMPUTE_LATENCY=0, READ_LATENCY=3
        sel = 2;
        run_txn("c_lat", 32'd6, 32'd8, 32'd14, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
